// File: rtl/rule_access_arb.sv
// Round-robin arbiter giving clients A and B single-outstanding access to a rule table, plus a zeroing sweep on clear.
// Grant to downstream request takes 1 cycle and downstream ack to client ack takes 1 cycle; a client stalls until it is acked.
module rule_access_arb #(
  parameter int TUPLE_WIDTH = 104,
  parameter int ADDR_BITS   = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   a_req,
  input  logic                   b_req,
  input  logic                   a_wr,
  input  logic                   b_wr,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [ADDR_BITS-1:0]   b_addr,
  input  logic [TUPLE_WIDTH-1:0] a_rule,
  input  logic [TUPLE_WIDTH-1:0] a_mask,
  input  logic [TUPLE_WIDTH-1:0] b_rule,
  input  logic [TUPLE_WIDTH-1:0] b_mask,
  output logic                   a_ack,
  output logic                   b_ack,
  output logic                   a_err,
  output logic                   b_err,
  output logic [TUPLE_WIDTH-1:0] rd_rule,
  output logic [TUPLE_WIDTH-1:0] rd_mask,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   rule_wr_req,
  output logic [ADDR_BITS-1:0]   rule_wr_addr,
  output logic [TUPLE_WIDTH-1:0] rule_wr,
  output logic [TUPLE_WIDTH-1:0] rule_wr_mask,
  input  logic                   rule_wr_ack,
  output logic                   rule_rd_req,
  output logic [ADDR_BITS-1:0]   rule_rd_addr,
  input  logic [TUPLE_WIDTH-1:0] rule_rd_in,
  input  logic [TUPLE_WIDTH-1:0] rule_rd_mask_in,
  input  logic                   rule_rd_ack
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLR_ISSUE, S_CLR_WAIT} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                 r_state, w_state_nxt;
  logic                   r_wr, r_gnt_b, r_last_b, r_clr_pend;
  logic [ADDR_BITS-1:0]   r_addr, r_clr_cnt;
  logic [TUPLE_WIDTH-1:0] r_rule, r_mask, r_rd_rule, r_rd_mask;
  logic [7:0]             r_to_cnt;
  logic                   r_a_ack, r_b_ack, r_a_err, r_b_err;
  logic                   w_in_clr, w_a_want, w_b_want, w_tmo;
  logic                   w_grant, w_grant_b, w_done, w_done_ok, w_clr_step, w_clr_last;
  logic                   w_wr_req, w_rd_req;

  assign w_in_clr = (r_state == S_CLR_ISSUE) || (r_state == S_CLR_WAIT);
  // A client still sees its own ack this cycle and has not yet dropped req; don't re-grant it.
  assign w_a_want = a_req & ~r_a_ack;
  assign w_b_want = b_req & ~r_b_ack;
  assign w_tmo    = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_b   = 1'b0;
    w_done      = 1'b0;
    w_done_ok   = 1'b0;
    w_clr_step  = 1'b0;
    w_clr_last  = 1'b0;
    w_wr_req    = 1'b0;
    w_rd_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_clr_pend || clear_req) begin
          w_state_nxt = S_CLR_ISSUE;
        end else if (w_a_want || w_b_want) begin
          w_grant     = 1'b1;
          w_grant_b   = w_b_want && (!w_a_want || !r_last_b);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wr_req    = r_wr;
        w_rd_req    = ~r_wr;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wr ? rule_wr_ack : rule_rd_ack) begin
          w_done      = 1'b1;
          w_done_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CLR_ISSUE: begin
        w_wr_req    = 1'b1;
        w_state_nxt = S_CLR_WAIT;
      end
      S_CLR_WAIT: begin
        if (rule_wr_ack || w_tmo) begin
          w_clr_step  = 1'b1;
          w_clr_last  = (r_clr_cnt == '1);
          w_state_nxt = w_clr_last ? S_IDLE : S_CLR_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr       <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_last_b   <= 1'b1;
      r_clr_pend <= 1'b0;
      r_addr     <= '0;
      r_clr_cnt  <= '0;
      r_rule     <= '0;
      r_mask     <= '0;
      r_rd_rule  <= '0;
      r_rd_mask  <= '0;
      r_to_cnt   <= '0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt_b <= w_grant_b;
        r_wr    <= w_grant_b ? b_wr   : a_wr;
        r_addr  <= w_grant_b ? b_addr : a_addr;
        r_rule  <= w_grant_b ? b_rule : a_rule;
        r_mask  <= w_grant_b ? b_mask : a_mask;
      end
      if ((r_state == S_ISSUE) || (r_state == S_CLR_ISSUE)) r_to_cnt <= '0;
      else if ((r_state == S_WAIT) || (r_state == S_CLR_WAIT)) r_to_cnt <= r_to_cnt + 8'd1;
      r_a_ack <= w_done & ~r_gnt_b;
      r_b_ack <= w_done &  r_gnt_b;
      r_a_err <= w_done & ~w_done_ok & ~r_gnt_b;
      r_b_err <= w_done & ~w_done_ok &  r_gnt_b;
      if (w_done_ok && !r_wr) begin
        r_rd_rule <= rule_rd_in;
        r_rd_mask <= rule_rd_mask_in;
      end
      if (w_done) r_last_b <= r_gnt_b;
      if (w_clr_step) r_clr_cnt <= r_clr_cnt + 1'b1;
      // A clear arriving mid-sweep is folded into the sweep already running.
      if (clear_req && !w_in_clr) r_clr_pend <= 1'b1;
      else if (w_clr_last)        r_clr_pend <= 1'b0;
    end
  end

  assign a_ack        = r_a_ack;
  assign b_ack        = r_b_ack;
  assign a_err        = r_a_err;
  assign b_err        = r_b_err;
  assign rd_rule      = r_rd_rule;
  assign rd_mask      = r_rd_mask;
  assign clear_busy   = r_clr_pend;
  assign rule_wr_req  = w_wr_req;
  assign rule_rd_req  = w_rd_req;
  assign rule_wr_addr = w_in_clr ? r_clr_cnt : r_addr;
  assign rule_wr      = w_in_clr ? '0 : r_rule;
  assign rule_wr_mask = w_in_clr ? '0 : r_mask;
  assign rule_rd_addr = r_addr;

endmodule

// File: tb/tb_rule_access_arb.sv
// Directed bench for rule_access_arb: arbitration, read/write, timeout, clear sweep and async reset.
module tb_rule_access_arb;
  localparam int W  = 104;
  localparam int AB = 5;
  localparam int TO = 8;

  localparam logic [W-1:0] R1 = 104'hA5A5_0000_1111_2222_3333_4444_55;
  localparam logic [W-1:0] M1 = 104'h00FF_0000_0000_0000_0000_0000_FF;
  localparam logic [W-1:0] R3 = 104'h1;
  localparam logic [W-1:0] R4 = 104'hC0FFEE;
  localparam logic [W-1:0] M3 = 104'hF0;

  logic          clk, resetn;
  logic          a_req, b_req, a_wr, b_wr;
  logic [AB-1:0] a_addr, b_addr;
  logic [W-1:0]  a_rule, a_mask, b_rule, b_mask;
  logic          a_ack, b_ack, a_err, b_err;
  logic [W-1:0]  rd_rule, rd_mask;
  logic          clear_req, clear_busy;
  logic          rule_wr_req, rule_wr_ack, rule_rd_req, rule_rd_ack;
  logic [AB-1:0] rule_wr_addr, rule_rd_addr;
  logic [W-1:0]  rule_wr, rule_wr_mask, rule_rd_in, rule_rd_mask_in;

  int n_chk = 0, n_bad = 0, cyc = 0;
  bit resp_on = 0, resp_wrong = 0;
  int resp_dly = 1;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, nz_cnt = 0, busy_cyc = 0;
  int last_wr_cyc = 0, last_rd_cyc = 0;
  logic [AB-1:0] last_rd_addr;
  logic [W-1:0]  last_wr_rule, last_wr_mask;
  logic [AB-1:0] wr_addr_q[$];
  int            done_cyc[2];
  logic          done_err[2];
  logic [W-1:0]  done_rd, done_rdm;

  rule_access_arb #(.TUPLE_WIDTH(W), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
    .a_addr(a_addr), .b_addr(b_addr),
    .a_rule(a_rule), .a_mask(a_mask), .b_rule(b_rule), .b_mask(b_mask),
    .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
    .rd_rule(rd_rule), .rd_mask(rd_mask),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .rule_wr_req(rule_wr_req), .rule_wr_addr(rule_wr_addr), .rule_wr(rule_wr),
    .rule_wr_mask(rule_wr_mask), .rule_wr_ack(rule_wr_ack),
    .rule_rd_req(rule_rd_req), .rule_rd_addr(rule_rd_addr),
    .rule_rd_in(rule_rd_in), .rule_rd_mask_in(rule_rd_mask_in), .rule_rd_ack(rule_rd_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream table model: acks resp_dly cycles after seeing a request.
  initial begin
    int  cnt;
    bit  pend_wr;
    cnt = 0;
    pend_wr = 1'b0;
    rule_wr_ack = 1'b0;
    rule_rd_ack = 1'b0;
    forever begin
      @(negedge clk);
      rule_wr_ack = 1'b0;
      rule_rd_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (pend_wr ^ resp_wrong) rule_wr_ack = 1'b1;
          else                      rule_rd_ack = 1'b1;
        end
      end
      if (resp_on && (rule_wr_req || rule_rd_req)) begin
        cnt = resp_dly;
        pend_wr = rule_wr_req;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rule_wr_req && rule_rd_req) both_cnt++;
    if (rule_wr_req) begin
      wr_cnt++;
      wr_addr_q.push_back(rule_wr_addr);
      last_wr_cyc  = cyc;
      last_wr_rule = rule_wr;
      last_wr_mask = rule_wr_mask;
      if (rule_wr != '0 || rule_wr_mask != '0) nz_cnt++;
    end
    if (rule_rd_req) begin
      rd_cnt++;
      last_rd_cyc  = cyc;
      last_rd_addr = rule_rd_addr;
    end
    if (clear_busy) busy_cyc++;
  end

  task automatic clr_log();
    wr_cnt = 0;
    rd_cnt = 0;
    nz_cnt = 0;
    busy_cyc = 0;
    wr_addr_q.delete();
  endtask

  task automatic client_txn(input bit is_b, input bit wr, input logic [AB-1:0] addr,
                            input logic [W-1:0] rule, input logic [W-1:0] mask);
    int n;
    if (!is_b) begin
      a_wr = wr; a_addr = addr; a_rule = rule; a_mask = mask; a_req = 1'b1;
    end else begin
      b_wr = wr; b_addr = addr; b_rule = rule; b_mask = mask; b_req = 1'b1;
    end
    done_cyc[is_b] = -1;
    done_err[is_b] = 1'bx;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (is_b ? b_ack : a_ack) begin
        done_cyc[is_b] = cyc;
        done_err[is_b] = is_b ? b_err : a_err;
        done_rd  = rd_rule;
        done_rdm = rd_mask;
        break;
      end
    end
    if (!is_b) a_req = 1'b0;
    else       b_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    a_req = 0; b_req = 0; a_wr = 0; b_wr = 0; a_addr = '0; b_addr = '0;
    a_rule = '0; a_mask = '0; b_rule = '0; b_mask = '0; clear_req = 0;
    rule_rd_in = '0; rule_rd_mask_in = '0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst wr_req", rule_wr_req, 0);
    chk("rst rd_req", rule_rd_req, 0);
    chk("rst acks", {a_ack, b_ack, a_err, b_err}, 0);
    chk("rst clear_busy", clear_busy, 0);
    chk("rst rd_rule", rd_rule, 0);
    chk("rst rd_mask", rd_mask, 0);
    chk("rst wr_addr", rule_wr_addr, 0);
    chk("rst wr_data", rule_wr, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // A write to entry 3, ack one cycle after request
    resp_on = 1; resp_dly = 1; clr_log();
    client_txn(0, 1, 5'd3, R1, M1);
    repeat (2) @(negedge clk);
    chk("a_wr count", wr_cnt, 1);
    chk("a_wr no read", rd_cnt, 0);
    chk("a_wr addr", wr_addr_q[0], 3);
    chk("a_wr rule", last_wr_rule, R1);
    chk("a_wr mask", last_wr_mask, M1);
    chk("a_wr ack latency", done_cyc[0] - last_wr_cyc, 2);
    chk("a_wr err", done_err[0], 0);

    // B read entry 7, ack two cycles after request
    rule_rd_in = 104'h5A; rule_rd_mask_in = 104'h3C; resp_dly = 2; clr_log();
    client_txn(1, 0, 5'd7, '0, '0);
    repeat (2) @(negedge clk);
    chk("b_rd count", rd_cnt, 1);
    chk("b_rd no write", wr_cnt, 0);
    chk("b_rd addr", last_rd_addr, 7);
    chk("b_rd data", done_rd, 104'h5A);
    chk("b_rd mask", done_rdm, 104'h3C);
    chk("b_rd ack latency", done_cyc[1] - last_rd_cyc, 3);
    chk("b_rd err", done_err[1], 0);

    // Tie after B was last served: A first, B back-to-back
    resp_dly = 1; clr_log();
    fork
      client_txn(0, 1, 5'd1, R1, M1);
      client_txn(1, 1, 5'd2, R4, M3);
    join
    repeat (2) @(negedge clk);
    chk("tie1 count", wr_cnt, 2);
    chk("tie1 first", wr_addr_q[0], 1);
    chk("tie1 second", wr_addr_q[1], 2);
    chk("tie1 spacing", done_cyc[1] - done_cyc[0], 3);

    // A served alone, then a tie must go to B
    client_txn(0, 1, 5'd4, R1, M1);
    repeat (2) @(negedge clk);
    clr_log();
    fork
      client_txn(0, 1, 5'd5, R1, M1);
      client_txn(1, 1, 5'd6, R4, M3);
    join
    repeat (2) @(negedge clk);
    chk("tie2 first", wr_addr_q[0], 6);
    chk("tie2 second", wr_addr_q[1], 5);
    chk("tie2 spacing", done_cyc[0] - done_cyc[1], 3);

    // A write with no downstream ack times out
    resp_on = 0; clr_log();
    client_txn(0, 1, 5'd9, R1, M1);
    repeat (2) @(negedge clk);
    chk("tmo err", done_err[0], 1);
    chk("tmo latency", done_cyc[0] - last_wr_cyc, 9);

    // B read answered only by a write ack: ignored, times out, read data kept
    resp_on = 1; resp_wrong = 1; clr_log();
    client_txn(1, 0, 5'd10, '0, '0);
    repeat (2) @(negedge clk);
    resp_wrong = 0;
    chk("wrong ack err", done_err[1], 1);
    chk("wrong ack latency", done_cyc[1] - last_rd_cyc, 9);
    chk("tmo rd_rule kept", done_rd, 104'h5A);

    // Clear during an A write, second clear absorbed, B waits for sweep
    clr_log();
    fork
      client_txn(0, 1, 5'd12, R3, M3);
      begin
        @(negedge clk); clear_req = 1;
        @(negedge clk); clear_req = 0;
        repeat (18) @(negedge clk); clear_req = 1;
        @(negedge clk); clear_req = 0;
      end
      begin
        repeat (2) @(negedge clk);
        client_txn(1, 1, 5'd20, R4, M3);
      end
    join
    repeat (2) @(negedge clk);
    begin
      int bad_ord;
      bad_ord = 0;
      for (int i = 0; i < 32; i++)
        if (wr_addr_q[i + 1] != AB'(i)) bad_ord++;
      chk("clr write count", wr_cnt, 34);
      chk("clr first is A", wr_addr_q[0], 12);
      chk("clr sweep order", bad_ord, 0);
      chk("clr last is B", wr_addr_q[33], 20);
      chk("clr nonzero writes", nz_cnt, 2);
      chk("clr busy cycles", busy_cyc, 66);
      chk("clr A err", done_err[0], 0);
      chk("clr B after sweep", done_cyc[1] - done_cyc[0], 68);
      chk("clr busy end", clear_busy, 0);
    end

    // Async reset while parked in a sweep wait
    clr_log(); resp_dly = 1;
    clear_req = 1;
    @(negedge clk); clear_req = 0;
    repeat (5) @(negedge clk);
    #1 resp_on = 0;
    repeat (4) @(negedge clk);
    chk("pre-rst busy", clear_busy, 1);
    chk("pre-rst sweep addr", rule_wr_addr, 3);
    #2 resetn = 1'b0;
    #1;
    chk("async rst busy", clear_busy, 0);
    chk("async rst addr", rule_wr_addr, 0);
    chk("async rst wr_req", rule_wr_req, 0);
    @(negedge clk); resetn = 1'b1; resp_on = 1;
    clr_log();
    repeat (20) @(negedge clk);
    chk("no sweep resume", wr_cnt, 0);
    chk("no busy resume", clear_busy, 0);
    client_txn(0, 1, 5'd2, R1, M1);
    repeat (2) @(negedge clk);
    chk("post-rst addr", wr_addr_q[0], 2);
    chk("post-rst err", done_err[0], 0);
    chk("never both req", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rule_access_arb.md
RULE_ACCESS_ARB -- requirements
Module: rule_access_arb

Interface
REQ-001 SHALL have parameter TUPLE_WIDTH, default 104, width of rule and mask words.
REQ-002 SHALL have parameter ADDR_BITS, default 5, rule-table address width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for a downstream ack (range 2..255).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req, b_req  in  1 each  client A (register path) / client B (bulk loader) request, level, held until own ack.
REQ-007 SHALL have ports a_wr, b_wr  in  1 each  1 = write, 0 = read; stable while req high.
REQ-008 SHALL have ports a_addr, b_addr  in  ADDR_BITS each  target entry.
REQ-009 SHALL have ports a_rule, a_mask, b_rule, b_mask  in  TUPLE_WIDTH each  write data and mask.
REQ-010 SHALL have ports a_ack, b_ack  out  1 each  one-cycle completion pulse.
REQ-011 SHALL have ports a_err, b_err  out  1 each  one-cycle pulse, coincident with ack, on timeout.
REQ-012 SHALL have ports rd_rule, rd_mask  out  TUPLE_WIDTH each  read result, valid with ack of a read.
REQ-013 SHALL have port clear_req  in  1  one-cycle pulse: zero the whole table.
REQ-014 SHALL have port clear_busy  out  1  high while a clear sweep runs.
REQ-015 SHALL have ports rule_wr_req, rule_wr_addr, rule_wr, rule_wr_mask  out  1/ADDR_BITS/TUPLE_WIDTH/TUPLE_WIDTH  downstream write port.
REQ-016 SHALL have port rule_wr_ack  in  1  downstream write-done pulse.
REQ-017 SHALL have ports rule_rd_req, rule_rd_addr  out  1/ADDR_BITS  downstream read port.
REQ-018 SHALL have ports rule_rd_in, rule_rd_mask_in, rule_rd_ack  in  TUPLE_WIDTH/TUPLE_WIDTH/1  downstream read data and done pulse.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT.
REQ-020 IDLE: clear pending has priority over clients; else grant one client round-robin; last-granted pointer reset to B so A wins the first tie.
REQ-021 IDLE->ISSUE on grant: latch wr/addr/rule/mask of granted client.
REQ-022 ISSUE: drive rule_wr_req or rule_rd_req high for exactly one cycle with latched address/data; ->WAIT; timeout counter cleared.
REQ-023 WAIT: on matching ack (rule_wr_ack for write, rule_rd_ack for read) pulse granted client's ack next cycle, register rd_rule/rd_mask on read, update pointer, ->IDLE.
REQ-024 WAIT: counter increments each cycle; reaching TIMEOUT without ack -> pulse granted ack and err, rd_rule/rd_mask unchanged, ->IDLE.
REQ-025 Acks arriving outside WAIT/CLR_WAIT, or of the wrong type, SHALL be ignored.
REQ-026 clear_req SHALL set a sticky pending flag, accepted in any state; an in-flight client transaction completes first.
REQ-027 CLR_ISSUE: one-cycle rule_wr_req, address = sweep counter, rule and mask all zeros; ->CLR_WAIT.
REQ-028 CLR_WAIT: on rule_wr_ack or timeout, counter +1; if counter was 2**ADDR_BITS-1 clear pending and clear_busy, ->IDLE, else ->CLR_ISSUE; counter wraps to 0.
REQ-029 clear_busy SHALL assert the cycle after clear_req is sampled and deassert on leaving CLR_WAIT for the last entry; clear_req during a sweep is absorbed (no second sweep).
REQ-030 Client requests SHALL NOT be granted while clear pending; they wait, not dropped.
REQ-031 At most one downstream request outstanding; rule_wr_req and rule_rd_req never high together.
REQ-032 Grant-to-downstream-request latency 1 cycle; downstream-ack-to-client-ack latency 1 cycle.

Reset
REQ-033 On resetn low, asynchronously: state IDLE, all req/ack/err/clear_busy outputs 0, rd_rule/rd_mask/address/data outputs 0, counters 0, pending flag 0, pointer = B.
REQ-034 Reset mid-transaction SHALL abandon it with no ack; behaviour resumes from IDLE on first edge after resetn high.

Verification
REQ-035 A write addr 3 with downstream ack 1 cycle after rule_wr_req -> one rule_wr_req pulse with addr 3, a_ack 1 cycle after ack, a_err 0.
REQ-036 A and B request same cycle, both held -> A served first, B next; repeat -> B served first on next tie.
REQ-037 B read addr 7, rule_rd_ack 2 cycles later with data 0x5A -> b_ack with rd_rule 0x5A, rule_wr_req never asserted.
REQ-038 A write, no ack, TIMEOUT=8 -> a_ack and a_err together 8 cycles after WAIT entry, state IDLE.
REQ-039 clear_req during A transaction, ADDR_BITS=5 -> A completes, then 32 zero writes addr 0..31, clear_busy high throughout, B request held meanwhile served after.
REQ-040 resetn low during CLR_WAIT -> all outputs 0 immediately, no sweep resumes.
